mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store access controller between the MEM pipeline stage and the word-wide data memory (combinational read, synchronous write on posedge clk).
- Accepts one access request at a time and stalls the pipeline while it runs.
- Performs sign- or zero-extended byte loads.
- Performs byte stores as a true read-modify-write, so only the addressed lane changes.
- Flags misaligned accesses without touching memory.

Parameters:
- AW, 32, address width of addr and mem_a.
- DW, 32, data width; fixed 32 (4 byte lanes).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  access request from MEM stage; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 halfword (HALFWORD_EN only), 10 word; 11 reserved, treated as word.
- uns  in  1  loads only: 1 zero-extend, 0 sign-extend.
- addr  in  AW  byte address.
- wdata  in  DW  store data; sub-word data taken from the low bits.
- rdata  out  DW  load result, registered; valid when done=1.
- done  out  1  one-cycle completion pulse.
- busy  out  1  pipeline stall request.
- misalign  out  1  pulses with done when the access was misaligned.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  word-aligned memory address {addr_q[AW-1:2],2'b00}.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data, combinational from mem_a.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - rdata, done, misalign, mem_we, mem_wd all 0.
  - Latched request registers cleared.
- Reset mid-operation: abort immediately, no further memory write.
  - mem_we is decoded from state, so a WR cycle interrupted by reset commits nothing.
- Byte lanes: little-endian. Lane k = bits [8k+7:8k], selected by addr[1:0]=k.
- States: IDLE, LD, RMW, WR, RESP.
- IDLE:
  - mem_we=0, mem_a=0.
  - busy=req, combinationally.
  - On req=1: latch addr, wdata, size, we, uns. Next state:
    - misaligned -> RESP
    - load -> LD
    - word store -> WR
    - byte store -> RMW
- LD:
  - mem_a=aligned addr_q.
  - Capture into rdata: word = mem_rd; byte = lane extended per uns_q.
  - Next: RESP.
- RMW:
  - Capture merge register = mem_rd with lane addr_q[1:0] replaced by wdata_q[7:0]; other lanes unchanged.
  - Next: WR.
- WR:
  - mem_we=1.
  - mem_wd = wdata_q (word store) or merge register (byte store).
  - Next: RESP.
- RESP:
  - done=1, busy=0. Next: IDLE.
  - req during RESP is ignored; it is accepted in the following IDLE cycle.
- busy is 1 in LD, RMW and WR.
- Latency (req accepted at edge 0):
  - Load or word store: done during cycle 2.
  - Byte store: done during cycle 3.
  - Misaligned: done during cycle 1.
- Misaligned (word with addr[1:0]!=0, halfword with addr[0]!=0):
  - No memory read or write.
  - misalign=1 with done.
  - rdata set to 0 for loads, unchanged for stores.
- Stores never modify rdata.
- Back-to-back requests: minimum 1 IDLE cycle between done and the next acceptance.

Optional Feature:
- Macro HALFWORD_EN.
- When defined:
  - size=01 is a halfword access on lanes {1,0} (addr[1]=0) or {3,2} (addr[1]=1).
  - Loads extend bit 15 per uns.
  - Stores use the RMW path replacing 16 bits with wdata[15:0].
  - addr[0]=1 is misaligned.
- When undefined: size=01 is treated exactly as a word access, including the word alignment check.

Test Plan:
- Word store then load: store addr=0x10 wdata=0xDEADBEEF.
  - Expect mem_we=1 for exactly one cycle, mem_a=0x10, done at cycle 2.
  - Then load 0x10 -> rdata=0xDEADBEEF, done at cycle 2.
- Byte store RMW: memory word 0x14 holds 0x11223344; store byte addr=0x16 wdata=0x000000AA.
  - Expect mem_wd=0x11AA3344 in WR, done at cycle 3, busy=1 for 3 cycles.
- Byte load extension: word 0x11223384; load byte addr=0x18.
  - uns=0 -> rdata=0xFFFFFF84.
  - uns=1 -> rdata=0x00000084.
- Misaligned: word load addr=0x21.
  - Expect done and misalign pulse in cycle 1, rdata=0, no mem_we, memory unchanged.
- Reset mid-operation: assert reset_n=0 during RMW of a byte store.
  - Expect mem_we never asserted, target word unchanged.
  - All outputs 0, state IDLE, next request served normally.
- HALFWORD_EN: word 0x11223344; halfword store addr=0x22 wdata=0xBEEF -> word=0xBEEF3344.
  - Halfword load addr=0x22, uns=0 -> rdata=0xFFFFBEEF.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - MEM-stage request/response and data-memory bus bundle
interface mem_access_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          done;
    logic          busy;
    logic          misalign;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_rd,
        output rdata, done, busy, misalign, mem_we, mem_a, mem_wd
    );

    modport master (
        output req, we, size, uns, addr, wdata, mem_rd,
        input  rdata, done, busy, misalign, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store controller with byte RMW and misalign detection; optional HALFWORD_EN
module mem_access_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_access_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD   = 3'd1,
        RMW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic          uns_q;
    logic          mis_q;
    logic [DW-1:0] merge_q;
    logic [DW-1:0] rdata_q;

    logic          in_byte;
    logic          in_half;
    logic          in_mis;
    logic          q_byte;
    logic          q_half;
    logic          q_word;

    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [DW-1:0] load_val;
    logic [DW-1:0] merge_d;
    logic [AW-1:0] aligned_a;

    logic          busy_c;
    logic          done_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_a_c;
    logic [DW-1:0] mem_wd_c;

    // Size decode: without halfword support size 01 behaves as a word access
    assign in_byte = (bus.size == 2'b00);
    assign q_byte  = (size_q == 2'b00);
`ifdef HALFWORD_EN
    assign in_half = (bus.size == 2'b01);
    assign q_half  = (size_q == 2'b01);
`else
    assign in_half = 1'b0;
    assign q_half  = 1'b0;
`endif
    assign q_word  = !q_byte && !q_half;
    assign in_mis  = in_half ? bus.addr[0]
                             : (!in_byte && (bus.addr[1:0] != 2'b00));

    assign aligned_a = {addr_q[AW-1:2], 2'b00};

    // Lane extraction and extension of the memory read word for loads
    always_comb begin
        rd_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    rd_byte = bus.mem_rd[7:0];
            2'd1:    rd_byte = bus.mem_rd[15:8];
            2'd2:    rd_byte = bus.mem_rd[23:16];
            default: rd_byte = bus.mem_rd[31:24];
        endcase
        rd_half = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        if (q_byte) begin
            load_val = {{(DW-8){!uns_q && rd_byte[7]}}, rd_byte};
        end else if (q_half) begin
            load_val = {{(DW-16){!uns_q && rd_half[15]}}, rd_half};
        end else begin
            load_val = bus.mem_rd;
        end
    end

    // Merge word for sub-word stores: replace only the addressed lane(s)
    always_comb begin
        merge_d = bus.mem_rd;
        if (q_half) begin
            if (addr_q[1]) merge_d[31:16] = wdata_q[15:0];
            else           merge_d[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    merge_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and state-decoded bus outputs
    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        mem_we_c = 1'b0;
        mem_a_c  = '0;
        mem_wd_c = '0;
        case (state)
            IDLE: begin
                busy_c = bus.req;
                if (bus.req) begin
                    if (in_mis)                       state_nx = RESP;
                    else if (!bus.we)                 state_nx = LD;
                    else if (!in_byte && !in_half)    state_nx = WR;
                    else                              state_nx = RMW;
                end
            end
            LD: begin
                busy_c   = 1'b1;
                mem_a_c  = aligned_a;
                state_nx = RESP;
            end
            RMW: begin
                busy_c   = 1'b1;
                mem_a_c  = aligned_a;
                state_nx = WR;
            end
            WR: begin
                busy_c   = 1'b1;
                mem_a_c  = aligned_a;
                mem_we_c = 1'b1;
                mem_wd_c = q_word ? wdata_q : merge_q;
                state_nx = RESP;
            end
            RESP: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, load result and merge register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                size_q  <= bus.size;
                we_q    <= bus.we;
                uns_q   <= bus.uns;
                mis_q   <= in_mis;
                if (in_mis && !bus.we) rdata_q <= '0;
            end
            if (state == LD)  rdata_q <= load_val;
            if (state == RMW) merge_q <= merge_d;
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.misalign = done_c && mis_q;
    assign bus.mem_we   = mem_we_c && we_q;
    assign bus.mem_a    = mem_a_c;
    assign bus.mem_wd   = mem_wd_c;
    assign bus.rdata    = rdata_q;

endmodule
